// File: rtl/uc_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the stack-processor control unit.
//   - data/address/opcode widths
//   - FSM state encoding (fixed values, 4 bits, visible as estado_atual)
//   - opcode constants
// Configuration macro used by the users of this package: UC_ILLEGAL_TRAP_EN
// -----------------------------------------------------------------------------
package uc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 5;
    localparam int INST_W = OP_W + ADDR_W;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_PUSH_RD  = 4'd2,
        ST_PUSH_WR  = 4'd3,
        ST_PUSHI    = 4'd4,
        ST_POP      = 4'd5,
        ST_POP_WR   = 4'd6,
        ST_ALU_T1   = 4'd7,
        ST_ALU_T2   = 4'd8,
        ST_ALU_PUSH = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_PUSH   = 5'd0;
    localparam logic [OP_W-1:0] OP_PUSH_I = 5'd1;
    localparam logic [OP_W-1:0] OP_POP    = 5'd2;
    localparam logic [OP_W-1:0] OP_DROP   = 5'd3;
    localparam logic [OP_W-1:0] OP_ADD    = 5'd4;
    localparam logic [OP_W-1:0] OP_SUB    = 5'd5;
    localparam logic [OP_W-1:0] OP_MUL    = 5'd6;
    localparam logic [OP_W-1:0] OP_DIV    = 5'd7;
    localparam logic [OP_W-1:0] OP_AND    = 5'd8;
    localparam logic [OP_W-1:0] OP_NAND   = 5'd9;
    localparam logic [OP_W-1:0] OP_OR     = 5'd10;
    localparam logic [OP_W-1:0] OP_XOR    = 5'd11;
    localparam logic [OP_W-1:0] OP_NOT    = 5'd12;
    localparam logic [OP_W-1:0] OP_GOTO   = 5'd13;
    localparam logic [OP_W-1:0] OP_IF     = 5'd14;
    localparam logic [OP_W-1:0] OP_HALT   = 5'd15;

endpackage

// File: rtl/uc_decode.sv
// -----------------------------------------------------------------------------
// uc_decode
// Combinational opcode decoder: selects the state that follows DECODE.
// Ports:
//   i_opcode  in  5  opcode field of the instruction being decoded
//   i_ula     in  1  ALU compare flag (IF branches when 1)
//   o_next    out    state to enter after DECODE
// Macro UC_ILLEGAL_TRAP_EN: when defined, opcodes 16..31 halt the machine;
// otherwise they behave as NOPs.
// -----------------------------------------------------------------------------
module uc_decode
    import uc_pkg::*;
(
    input  logic [OP_W-1:0] i_opcode,
    input  logic            i_ula,
    output state_t          o_next
);

    always_comb begin
        o_next = ST_FETCH;
        case (i_opcode)
            OP_PUSH:   o_next = ST_PUSH_RD;
            OP_PUSH_I: o_next = ST_PUSHI;
            OP_POP,
            OP_DROP:   o_next = ST_POP;
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
            OP_NAND, OP_OR, OP_XOR, OP_NOT:
                       o_next = ST_ALU_T1;
            OP_GOTO:   o_next = ST_JUMP;
            OP_IF:     o_next = i_ula ? ST_JUMP : ST_FETCH;
            OP_HALT:   o_next = ST_HALT;
            default: begin
`ifdef UC_ILLEGAL_TRAP_EN
                o_next = ST_HALT;
`else
                o_next = ST_FETCH;
`endif
            end
        endcase
    end

endmodule

// File: rtl/uc_ctrl.sv
// -----------------------------------------------------------------------------
// uc_ctrl
// Multi-cycle control unit of the 16-bit stack processor. Fetches 10-bit
// instructions, decodes them and sequences stack, RAM, ALU temp registers and
// ALU opcode. Owns the program counter and the state register.
// Ports:
//   clock, reset (async, active low)
//   inst[9:0]        ROM output, [9:5] opcode, [4:0] operand
//   data_mem[15:0]   RAM read data
//   controle_ula     ALU compare flag, sampled in DECODE
//   push/pop, ram_wren, controle_pilha, load_temp1/2   control levels
//   clock_pilha/rom/ram/temp1/temp2                    one-cycle strobes
//   a_rom[4:0] program counter, a_ram[4:0] RAM address
//   data_pilha[15:0] stack write data, opcode[4:0] latched ALU opcode
//   estado_atual[3:0] current FSM state (observation)
// Macro UC_ILLEGAL_TRAP_EN (in uc_decode): opcodes 16..31 halt when defined.
//
// Every output is a register loaded on the edge that enters a state with the
// value that state calls for, so outputs line up exactly with estado_atual.
// Handshake: none; the unit is a fixed-latency sequencer, strobes are plain
// one-cycle register pulses (never gated clocks).
// -----------------------------------------------------------------------------
module uc_ctrl
    import uc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [INST_W-1:0] inst,
    input  logic [DATA_W-1:0] data_mem,
    input  logic              controle_ula,
    output logic              push,
    output logic              pop,
    output logic              ram_wren,
    output logic              controle_pilha,
    output logic              clock_pilha,
    output logic              clock_rom,
    output logic              clock_ram,
    output logic              clock_temp1,
    output logic              clock_temp2,
    output logic [ADDR_W-1:0] a_rom,
    output logic [DATA_W-1:0] data_pilha,
    output logic [ADDR_W-1:0] a_ram,
    output logic              load_temp1,
    output logic              load_temp2,
    output logic [OP_W-1:0]   opcode,
    output logic [3:0]        estado_atual
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INST_W-1:0]   r_ir;

    state_t              w_dec_next;
    state_t              w_next;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [ADDR_W-1:0]   w_operand;

    assign estado_atual = r_state;

    uc_decode u_decode (
        .i_opcode (inst[INST_W-1:ADDR_W]),
        .i_ula    (controle_ula),
        .o_next   (w_dec_next)
    );

    // Operand used by the state being entered: states entered straight from
    // DECODE must take it from inst, since IR is loaded on that same edge.
    assign w_operand = (r_state == ST_DECODE) ? inst[ADDR_W-1:0] : r_ir[ADDR_W-1:0];

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:   w_next = ST_DECODE;
            ST_DECODE:  w_next = w_dec_next;
            ST_PUSH_RD: w_next = ST_PUSH_WR;
            // POP and DROP share the pop state; only POP goes on to write RAM.
            ST_POP:     w_next = (r_ir[INST_W-1:ADDR_W] == OP_POP) ? ST_POP_WR : ST_FETCH;
            ST_ALU_T1:  w_next = ST_ALU_T2;
            ST_ALU_T2:  w_next = ST_ALU_PUSH;
            ST_HALT:    w_next = ST_HALT;
            default:    w_next = ST_FETCH;
        endcase
    end

    // PC increments in DECODE; JUMP then overwrites it with the operand.
    always_comb begin
        w_pc_next = r_pc;
        if (r_state == ST_DECODE) begin
            w_pc_next = r_pc + 5'd1;
        end else if (r_state == ST_JUMP) begin
            w_pc_next = r_ir[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_FETCH;
            r_pc           <= '0;
            r_ir           <= '0;
            push           <= 1'b0;
            pop            <= 1'b0;
            ram_wren       <= 1'b0;
            controle_pilha <= 1'b0;
            clock_pilha    <= 1'b0;
            clock_rom      <= 1'b0;
            clock_ram      <= 1'b0;
            clock_temp1    <= 1'b0;
            clock_temp2    <= 1'b0;
            a_rom          <= '0;
            data_pilha     <= '0;
            a_ram          <= '0;
            load_temp1     <= 1'b0;
            load_temp2     <= 1'b0;
            opcode         <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (r_state == ST_DECODE) begin
                r_ir   <= inst;
                opcode <= inst[INST_W-1:ADDR_W];
            end

            push           <= 1'b0;
            pop            <= 1'b0;
            ram_wren       <= 1'b0;
            controle_pilha <= 1'b0;
            clock_pilha    <= 1'b0;
            clock_rom      <= 1'b0;
            clock_ram      <= 1'b0;
            clock_temp1    <= 1'b0;
            clock_temp2    <= 1'b0;
            data_pilha     <= '0;
            a_ram          <= '0;
            load_temp1     <= 1'b0;
            load_temp2     <= 1'b0;
            a_rom          <= w_pc_next;

            case (w_next)
                ST_FETCH: begin
                    clock_rom <= 1'b1;
                end
                ST_PUSH_RD: begin
                    a_ram     <= w_operand;
                    clock_ram <= 1'b1;
                end
                ST_PUSH_WR: begin
                    data_pilha  <= data_mem;
                    push        <= 1'b1;
                    clock_pilha <= 1'b1;
                end
                ST_PUSHI: begin
                    data_pilha  <= {{(DATA_W-ADDR_W){1'b0}}, w_operand};
                    push        <= 1'b1;
                    clock_pilha <= 1'b1;
                end
                ST_POP: begin
                    pop         <= 1'b1;
                    clock_pilha <= 1'b1;
                end
                ST_POP_WR: begin
                    a_ram     <= w_operand;
                    ram_wren  <= 1'b1;
                    clock_ram <= 1'b1;
                end
                ST_ALU_T1: begin
                    pop         <= 1'b1;
                    clock_pilha <= 1'b1;
                    load_temp1  <= 1'b1;
                    clock_temp1 <= 1'b1;
                end
                ST_ALU_T2: begin
                    pop         <= 1'b1;
                    clock_pilha <= 1'b1;
                    load_temp2  <= 1'b1;
                    clock_temp2 <= 1'b1;
                end
                ST_ALU_PUSH: begin
                    controle_pilha <= 1'b1;
                    push           <= 1'b1;
                    clock_pilha    <= 1'b1;
                end
                ST_HALT: begin
                    // Halted machine drives every output low, opcode included.
                    a_rom  <= '0;
                    opcode <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uc_ctrl
// Directed + random instruction stream for uc_ctrl. The reference model turns
// each instruction into its list of visited states and the outputs each state
// should show, straight from the instruction table; every cycle is compared.
// -----------------------------------------------------------------------------
module tb_uc_ctrl;
    import uc_pkg::*;

    logic              clock;
    logic              reset;
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] data_mem;
    logic              controle_ula;
    logic              push, pop, ram_wren, controle_pilha;
    logic              clock_pilha, clock_rom, clock_ram, clock_temp1, clock_temp2;
    logic [ADDR_W-1:0] a_rom;
    logic [DATA_W-1:0] data_pilha;
    logic [ADDR_W-1:0] a_ram;
    logic              load_temp1, load_temp2;
    logic [OP_W-1:0]   opcode;
    logic [3:0]        estado_atual;

    int checks = 0;
    int errors = 0;

    // model state
    logic [4:0] m_pc;
    logic [4:0] m_op;
    bit         m_after_reset;

    uc_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .inst           (inst),
        .data_mem       (data_mem),
        .controle_ula   (controle_ula),
        .push           (push),
        .pop            (pop),
        .ram_wren       (ram_wren),
        .controle_pilha (controle_pilha),
        .clock_pilha    (clock_pilha),
        .clock_rom      (clock_rom),
        .clock_ram      (clock_ram),
        .clock_temp1    (clock_temp1),
        .clock_temp2    (clock_temp2),
        .a_rom          (a_rom),
        .data_pilha     (data_pilha),
        .a_ram          (a_ram),
        .load_temp1     (load_temp1),
        .load_temp2     (load_temp2),
        .opcode         (opcode),
        .estado_atual   (estado_atual)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [41:0] obs_vec;
    assign obs_vec = {push, pop, ram_wren, controle_pilha, clock_pilha, clock_rom,
                      clock_ram, clock_temp1, clock_temp2, load_temp1, load_temp2,
                      a_rom, data_pilha, a_ram, opcode};

    // Expected output vector for one visited state (same packing as obs_vec).
    function automatic logic [41:0] exp_vec(input int s, input logic [4:0] operand,
                                            input logic [15:0] d, input logic [4:0] pc,
                                            input logic [4:0] old_op, input logic [4:0] new_op,
                                            input bit after_rst);
        logic e_push, e_pop, e_wren, e_cp, e_cpil, e_crom, e_cram, e_ct1, e_ct2, e_lt1, e_lt2;
        logic [4:0]  e_arom, e_aram, e_op;
        logic [15:0] e_dp;
        {e_push, e_pop, e_wren, e_cp, e_cpil, e_crom, e_cram, e_ct1, e_ct2, e_lt1, e_lt2} = '0;
        e_aram = '0;
        e_dp   = '0;
        e_arom = pc + 5'd1;
        e_op   = new_op;
        case (s)
            0: begin e_crom = !after_rst; e_arom = pc; e_op = old_op; end
            1: begin e_arom = pc; e_op = old_op; end
            2: begin e_aram = operand; e_cram = 1'b1; end
            3: begin e_dp = d; e_push = 1'b1; e_cpil = 1'b1; end
            4: begin e_dp = 16'(operand); e_push = 1'b1; e_cpil = 1'b1; end
            5: begin e_pop = 1'b1; e_cpil = 1'b1; end
            6: begin e_aram = operand; e_wren = 1'b1; e_cram = 1'b1; end
            7: begin e_pop = 1'b1; e_cpil = 1'b1; e_lt1 = 1'b1; e_ct1 = 1'b1; end
            8: begin e_pop = 1'b1; e_cpil = 1'b1; e_lt2 = 1'b1; e_ct2 = 1'b1; end
            9: begin e_cp = 1'b1; e_push = 1'b1; e_cpil = 1'b1; end
            11: begin e_arom = '0; e_op = '0; end
            default: ;
        endcase
        return {e_push, e_pop, e_wren, e_cp, e_cpil, e_crom, e_cram, e_ct1, e_ct2,
                e_lt1, e_lt2, e_arom, e_dp, e_aram, e_op};
    endfunction

    task automatic check_vec(input string tag, input logic [41:0] exp);
        checks++;
        assert (obs_vec === exp) else begin
            errors++;
            $error("FAIL %s outputs observed=%h expected=%h", tag, obs_vec, exp);
        end
    endtask

    task automatic check_state(input string tag, input int exp);
        checks++;
        assert (estado_atual === 4'(exp)) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, estado_atual, exp);
        end
    endtask

    // Assert reset asynchronously, check cleared outputs, release just after a
    // rising edge so the next falling edge still sees the reset FETCH state.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check_state({tag, ".rst"}, 0);
        check_vec({tag, ".rst"}, '0);
        @(posedge clock);
        #1 reset = 1'b1;
        m_pc = '0;
        m_op = '0;
        m_after_reset = 1'b1;
    endtask

    function automatic logic [9:0] mk(input int op, input int operand);
        return {5'(op), 5'(operand)};
    endfunction

    // Driver + model: runs one instruction (or its first max_states states).
    task automatic run_instr(input logic [9:0] ins, input bit ula, input logic [15:0] dval,
                             input int max_states, input string tag);
        int         seq[$];
        logic [4:0] op;
        logic [4:0] operand;
        logic [4:0] new_op;
        op      = ins[9:5];
        operand = ins[4:0];
        seq     = {0, 1};
        if (op == 0)                    begin seq.push_back(2); seq.push_back(3); end
        else if (op == 1)               seq.push_back(4);
        else if (op == 2)               begin seq.push_back(5); seq.push_back(6); end
        else if (op == 3)               seq.push_back(5);
        else if (op >= 4 && op <= 12)   begin seq.push_back(7); seq.push_back(8); seq.push_back(9); end
        else if (op == 13)              seq.push_back(10);
        else if (op == 14)              begin if (ula) seq.push_back(10); end
        else if (op == 15)              seq.push_back(11);
        else begin
`ifdef UC_ILLEGAL_TRAP_EN
            seq.push_back(11);
`endif
        end
        new_op   = (seq[seq.size()-1] == 11) ? 5'd0 : op;
        data_mem = dval;
        for (int k = 0; k < seq.size() && k < max_states; k++) begin
            @(negedge clock);
            if (k >= 2) begin
                // instruction already latched: later inst changes must be ignored
                inst         = 10'($urandom);
                controle_ula = 1'($urandom);
            end
            check_state($sformatf("%s.s%0d", tag, k), seq[k]);
            check_vec($sformatf("%s.s%0d", tag, k),
                      exp_vec(seq[k], operand, dval, m_pc, m_op, new_op, m_after_reset));
            if (k == 0) begin
                inst          = ins;
                controle_ula  = ula;
                m_after_reset = 1'b0;
            end
        end
        if (max_states >= seq.size()) begin
            m_pc = (seq[seq.size()-1] == 10) ? operand : m_pc + 5'd1;
            m_op = new_op;
        end
    endtask

    initial begin
        int op;
        reset        = 1'b0;
        inst         = '0;
        data_mem     = '0;
        controle_ula = 1'b0;
        m_pc = '0;
        m_op = '0;
        m_after_reset = 1'b1;

        do_reset("init");

        run_instr(mk(0, 0),   1'b0, 16'h1234, 99, "push_m0");
        run_instr(mk(1, 7),   1'b0, 16'hbeef, 99, "pushi7");
        run_instr(mk(2, 3),   1'b0, 16'h0f0f, 99, "pop_m3");
        run_instr(mk(3, 0),   1'b0, 16'h0000, 99, "drop");
        run_instr(mk(4, 0),   1'b0, 16'h5555, 99, "alu_add");
        run_instr(mk(12, 31), 1'b1, 16'h0001, 99, "alu_not");
        run_instr(mk(13, 20), 1'b0, 16'h0000, 99, "goto20");
        run_instr(mk(14, 9),  1'b0, 16'h0000, 99, "if_false");
        run_instr(mk(14, 9),  1'b1, 16'h0000, 99, "if_true");
        run_instr(mk(20, 5),  1'b1, 16'h0000, 99, "nop20");
        run_instr(mk(0, 31),  1'b0, 16'hffff, 99, "push_m31");

        // PC wrap 31 -> 0
        run_instr(mk(13, 31), 1'b0, 16'h0000, 99, "goto31");
        run_instr(mk(1, 31),  1'b0, 16'h0000, 99, "pushi_wrap");

        for (int n = 0; n < 80; n++) begin
`ifdef UC_ILLEGAL_TRAP_EN
            op = $urandom_range(0, 14);
`else
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 14);
`endif
            run_instr(mk(op, $urandom_range(0, 31)), 1'($urandom), 16'($urandom), 99,
                      $sformatf("rnd%0d", n));
        end

        // reset in the middle of a PUSH aborts to FETCH with PC=0
        run_instr(mk(0, 4), 1'b0, 16'h4444, 3, "abort");
        do_reset("abort");
        run_instr(mk(21, 0), 1'b0, 16'h0000, 99, "post_abort");

        run_instr(mk(15, 0), 1'b0, 16'h0000, 99, "halt");
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            inst         = 10'($urandom);
            controle_ula = 1'($urandom);
            check_state($sformatf("halt_hold%0d", n), 11);
            check_vec($sformatf("halt_hold%0d", n), '0);
        end
        @(negedge clock);
        do_reset("halt");
        run_instr(mk(1, 2), 1'b0, 16'h0000, 99, "after_halt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
